// File: rtl/out_compare_pkg.sv
// Shared types and helpers for the output compare monitor.
//   state_e    : monitor state encoding
//   ch_lsb()   : low bit index of a channel inside a packed CH*W bus
//   cnt_w_for(): minimum counter width able to hold a given value (>= 1)
package out_compare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

    function automatic int unsigned cnt_w_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/out_compare_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   clr   : synchronous clear (wins over inc)
//   inc   : count enable; holds at all-ones once reached
//   cnt   : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/out_compare_monitor.sv
// Compares CH channels of W-bit DUT outputs against reference outputs inside
// an armed window, with sticky per-channel flags, saturating counters and
// first-failure capture.
//   clk, rstn        : clock, asynchronous active-low reset
//   start, stop      : window arm / close pulses (start wins)
//   dut_out, ref_out : packed CH*W compared buses
//   mask             : per-channel compare enable
//   busy, done, pass : status
//   mismatch         : per-channel result of the previous compared cycle
//   sticky_fail      : per-channel OR of mismatches since start
//   err_cnt, cyc_cnt : failing / compared cycle counts (saturating)
//   first_cyc, first_ch : cycle index and bitmap of the first failure
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | not armed, results held at 0
// ST_SETTLE | armed, settle down-counter running, no comparison
// ST_RUN    | comparing every cycle
// ST_DONE   | window closed, results held until next start
module out_compare_monitor
    import out_compare_pkg::*;
#(
    parameter int unsigned CH     = 4,
    parameter int unsigned W      = 1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic [CH*W-1:0]   dut_out,
    input  logic [CH*W-1:0]   ref_out,
    input  logic [CH-1:0]     mask,
    output logic              busy,
    output logic              done,
    output logic [CH-1:0]     mismatch,
    output logic [CH-1:0]     sticky_fail,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  first_cyc,
    output logic [CH-1:0]     first_ch,
    output logic              pass
);

    localparam int unsigned SETTLE_W = cnt_w_for(SETTLE);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);

    state_e              state_q;
    state_e              state_d;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic [CH-1:0]       m;
    logic                any_m;
    logic                compare_en;
    logic                first_seen_q;

    // Case inequality so X/Z on either side is reported as a mismatch in
    // simulation; synthesis treats it as ordinary inequality.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign m[i] = mask[i] && (dut_out[ch_lsb(i, W) +: W] !== ref_out[ch_lsb(i, W) +: W]);
    end

    assign any_m = |m;

    // Neither a stop cycle nor a restarting start cycle is compared.
    assign compare_en = (state_q == ST_RUN) && !start && !stop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_SETTLE: begin
                    if (stop) begin
                        state_d = ST_DONE;
                    end else if (settle_cnt_q == SETTLE_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:    if (stop) state_d = ST_DONE;
                ST_DONE:   state_d = ST_DONE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SETTLE: busy = 1'b1;
            ST_RUN:    busy = 1'b1;
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
        pass = done && (err_cnt == '0);
    end

    // Settle timer: loaded with SETTLE on start, terminal count at 1 means
    // the last settle cycle, so RUN begins after exactly SETTLE cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle_cnt_q <= '0;
        end else if (start) begin
            settle_cnt_q <= SETTLE_LOAD;
        end else if (state_q == ST_SETTLE && settle_cnt_q != '0) begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mismatch     <= '0;
            sticky_fail  <= '0;
            first_cyc    <= '0;
            first_ch     <= '0;
            first_seen_q <= 1'b0;
        end else if (start) begin
            mismatch     <= '0;
            sticky_fail  <= '0;
            first_cyc    <= '0;
            first_ch     <= '0;
            first_seen_q <= 1'b0;
        end else if (compare_en) begin
            mismatch    <= m;
            sticky_fail <= sticky_fail | m;
            if (any_m && !first_seen_q) begin
                first_cyc    <= cyc_cnt;
                first_ch     <= m;
                first_seen_q <= 1'b1;
            end
        end else begin
            mismatch <= '0;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cyc_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start),
        .inc  (compare_en),
        .cnt  (cyc_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start),
        .inc  (compare_en && any_m),
        .cnt  (err_cnt)
    );

endmodule

// File: tb/tb_out_compare_monitor.sv
module tb_out_compare_monitor;

    localparam int unsigned CH     = 4;
    localparam int unsigned W      = 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SETTLE = 2;

    logic             clk;
    logic             rstn;
    logic             start;
    logic             stop;
    logic [CH*W-1:0]  dut_out;
    logic [CH*W-1:0]  ref_out;
    logic [CH-1:0]    mask;
    logic             busy;
    logic             done;
    logic [CH-1:0]    mismatch;
    logic [CH-1:0]    sticky_fail;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] first_cyc;
    logic [CH-1:0]    first_ch;
    logic             pass;

    int total;
    int bad;

    out_compare_monitor #(
        .CH(CH), .W(W), .CNT_W(CNT_W), .SETTLE(SETTLE)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .stop        (stop),
        .dut_out     (dut_out),
        .ref_out     (ref_out),
        .mask        (mask),
        .busy        (busy),
        .done        (done),
        .mismatch    (mismatch),
        .sticky_fail (sticky_fail),
        .err_cnt     (err_cnt),
        .cyc_cnt     (cyc_cnt),
        .first_cyc   (first_cyc),
        .first_ch    (first_ch),
        .pass        (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".mismatch"}, 32'(mismatch), 0);
        chk({tag, ".sticky"}, 32'(sticky_fail), 0);
        chk({tag, ".err_cnt"}, 32'(err_cnt), 0);
        chk({tag, ".cyc_cnt"}, 32'(cyc_cnt), 0);
        chk({tag, ".first_cyc"}, 32'(first_cyc), 0);
        chk({tag, ".first_ch"}, 32'(first_ch), 0);
        chk({tag, ".pass"}, 32'(pass), 0);
    endtask

    // start pulse then the SETTLE cycles; returns with state RUN
    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (SETTLE) tick();
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rstn    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        dut_out = '0;
        ref_out = '0;
        mask    = '0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            start   = 1'($urandom_range(0, 1));
            stop    = 1'($urandom_range(0, 1));
            dut_out = 4'($urandom);
            ref_out = 4'($urandom);
            mask    = 4'($urandom);
            #10;
        end
        chk_all_zero("rst");
        start = 1'b0;
        stop  = 1'b0;
        mask  = 4'hF;
        dut_out = 4'h5;
        ref_out = 4'hA;
        #2 rstn = 1'b1;
        repeat (3) tick();
        chk_all_zero("idle");

        // Clean run: 10 compared cycles
        dut_out = 4'h0;
        ref_out = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clean.busy_settle", 32'(busy), 1);
        tick();
        tick();
        chk("clean.cyc_after_settle", 32'(cyc_cnt), 0);
        for (int c = 0; c < 10; c++) begin
            dut_out = 4'(c);
            ref_out = 4'(c);
            tick();
        end
        chk("clean.busy_run", 32'(busy), 1);
        dut_out = 4'hF;  // stop cycle is not compared
        do_stop();
        chk("clean.done", 32'(done), 1);
        chk("clean.busy", 32'(busy), 0);
        chk("clean.cyc_cnt", 32'(cyc_cnt), 10);
        chk("clean.err_cnt", 32'(err_cnt), 0);
        chk("clean.pass", 32'(pass), 1);
        chk("clean.sticky", 32'(sticky_fail), 0);
        chk("clean.mismatch", 32'(mismatch), 0);

        // ch2 differs on RUN cycles 3 and 4
        ref_out = 4'h3;
        dut_out = 4'h3;
        arm();
        for (int c = 0; c < 8; c++) begin
            dut_out = (c == 3 || c == 4) ? 4'h7 : 4'h3;
            tick();
            if (c == 3) chk("pulse.mismatch_c3", 32'(mismatch), 32'h4);
            if (c == 4) begin
                chk("pulse.mismatch_c4", 32'(mismatch), 32'h4);
                chk("pulse.err_c4", 32'(err_cnt), 2);
            end
            if (c == 5) chk("pulse.mismatch_c5", 32'(mismatch), 0);
        end
        do_stop();
        chk("pulse.err_cnt", 32'(err_cnt), 2);
        chk("pulse.cyc_cnt", 32'(cyc_cnt), 8);
        chk("pulse.first_cyc", 32'(first_cyc), 3);
        chk("pulse.first_ch", 32'(first_ch), 32'h4);
        chk("pulse.sticky", 32'(sticky_fail), 32'h4);
        chk("pulse.pass", 32'(pass), 0);

        // Mismatch on ch0 only during SETTLE, masked ch1 mismatch in RUN
        ref_out = 4'h0;
        dut_out = 4'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clears.err", 32'(err_cnt), 0);
        chk("start_clears.sticky", 32'(sticky_fail), 0);
        tick();
        chk("settle.mismatch", 32'(mismatch), 0);
        tick();
        mask    = 4'b1101;
        dut_out = 4'h2;
        repeat (5) tick();
        chk("mask.mismatch", 32'(mismatch), 0);
        mask    = 4'hF;  // re-enabled mask only affects later cycles
        tick();
        chk("mask.reenable", 32'(mismatch), 32'h2);
        dut_out = 4'h0;
        do_stop();
        chk("mask.err_cnt", 32'(err_cnt), 1);
        chk("mask.first_cyc", 32'(first_cyc), 5);
        chk("mask.cyc_cnt", 32'(cyc_cnt), 6);

        // Masked-only run passes
        dut_out = 4'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        mask    = 4'b1101;
        dut_out = 4'h2;
        repeat (5) tick();
        do_stop();
        chk("settle_mask.err_cnt", 32'(err_cnt), 0);
        chk("settle_mask.pass", 32'(pass), 1);
        chk("settle_mask.cyc_cnt", 32'(cyc_cnt), 5);
        chk("settle_mask.sticky", 32'(sticky_fail), 0);
        mask = 4'hF;

        // start and stop together in DONE, then stop during SETTLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("restart.busy", 32'(busy), 1);
        chk("restart.done", 32'(done), 0);
        chk("restart.cyc_cnt", 32'(cyc_cnt), 0);
        do_stop();
        chk("settle_stop.done", 32'(done), 1);
        chk("settle_stop.cyc_cnt", 32'(cyc_cnt), 0);
        chk("settle_stop.pass", 32'(pass), 1);
        do_stop();
        chk("done_stop_ignored", 32'(done), 1);

        // Saturation with 20 failing cycles on ch3
        ref_out = 4'h0;
        dut_out = 4'h0;
        arm();
        dut_out = 4'h8;
        repeat (20) tick();
        dut_out = 4'h0;
        do_stop();
        chk("sat.err_cnt", 32'(err_cnt), 15);
        chk("sat.cyc_cnt", 32'(cyc_cnt), 15);
        chk("sat.first_cyc", 32'(first_cyc), 0);
        chk("sat.first_ch", 32'(first_ch), 32'h8);
        chk("sat.sticky", 32'(sticky_fail), 32'h8);

        // First failure after cyc_cnt saturated captures the saturated value
        arm();
        repeat (16) tick();
        dut_out = 4'h3;
        tick();
        dut_out = 4'h0;
        do_stop();
        chk("sat_first.first_cyc", 32'(first_cyc), 15);
        chk("sat_first.first_ch", 32'(first_ch), 32'h3);
        chk("sat_first.err_cnt", 32'(err_cnt), 1);

        // Reset mid-run clears asynchronously
        arm();
        dut_out = 4'h6;
        repeat (3) tick();
        chk("pre_rst.err_cnt", 32'(err_cnt), 3);
        #2 rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        rstn = 1'b1;
        dut_out = 4'h0;
        repeat (2) tick();
        chk("post_rst.busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
